// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low abcdefg glyphs and scan FSM states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCEPT = 2'd2,
    HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Maps an active-low abcdefg pattern back to its hex nibble, flagging non-hex glyphs.
// Latency: combinational.
// Backpressure: none.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       nibble_vld
);

  always_comb begin
    nibble     = 4'h0;
    nibble_vld = 1'b1;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: nibble_vld = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reassembles the word shown on a scanned, active-low 8-digit seven-segment display.
// Latency: digit stored STABLE_CYCLES+1 clocks after its pattern appears; value one clock after the last digit.
// Backpressure: none; passive monitor that never stalls the scanned display.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     Anode_Activate,
  input  logic [6:0]            LED_out,
  output logic [4*DIGITS-1:0]   value,
  output logic                  value_valid,
  output logic                  glyph_err,
  output logic                  scan_err
);

  localparam int         IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [DIGITS-1:0]        anode_q;
  logic [6:0]               seg_q;
  logic                     chg_q;
  logic [7:0]               cnt_q;
  logic                     sample_chg;

  state_t                   state_q, state_d;
  logic [DIGITS-1:0]        seen_q, seen_d;
  logic [DIGITS-1:0][3:0]   digit_q;

  logic [DIGITS-1:0]        anode_n;
  logic                     blank, onehot;
  logic [IDX_W-1:0]         idx;
  logic                     armed, fire, store, bad_glyph, scan_bad, frame_done;
  logic [3:0]               dec_nib;
  logic                     dec_vld;

  // Sample stage; the stability counter tracks how long the registered copy has held.
  assign sample_chg = {Anode_Activate, LED_out} != {anode_q, seg_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode_q <= '1;
      seg_q   <= SEG_BLANK;
      chg_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      anode_q <= Anode_Activate;
      seg_q   <= LED_out;
      chg_q   <= sample_chg;
      if (sample_chg)
        cnt_q <= 8'd1;
      else if (cnt_q < STABLE)
        cnt_q <= cnt_q + 8'd1;
    end
  end

  seg7_glyph_decode u_glyph (
    .seg        (seg_q),
    .nibble     (dec_nib),
    .nibble_vld (dec_vld)
  );

  always_comb begin
    anode_n = ~anode_q;
    blank   = (anode_n == '0);
    onehot  = !blank && ((anode_n & (anode_n - 1'b1)) == '0);
    idx     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (anode_n[i])
        idx = IDX_W'(i);
    end
  end

  // The action fires on the edge that leaves SETTLE, so ACCEPT is the cycle its effects are visible.
  always_comb begin
    armed      = (state_q == SETTLE) || chg_q;
    fire       = armed && (cnt_q == STABLE);
    store      = fire && onehot;
    bad_glyph  = store && !dec_vld;
    scan_bad   = fire && !blank && !onehot;
    frame_done = &seen_q;

    state_d = state_q;
    if (fire)
      state_d = ACCEPT;
    else if (armed)
      state_d = SETTLE;
    else if (state_q == ACCEPT)
      state_d = HOLD;

    seen_d = frame_done ? '0 : seen_q;
    if (store)
      seen_d[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      seen_q      <= '0;
      digit_q     <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      glyph_err   <= 1'b0;
      scan_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      seen_q      <= seen_d;
      value_valid <= frame_done;
      scan_err    <= scan_bad;
      // A bad glyph landing on the completion cycle belongs to the new frame.
      glyph_err   <= (frame_done ? 1'b0 : glyph_err) | bad_glyph;
      if (frame_done)
        value <= digit_q;
      if (store)
        digit_q[idx] <= dec_vld ? dec_nib : 4'h0;
    end
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
Monitor-side decoder for the multiplexed 8-digit seven-segment interface driven by the processor top-level (Anode_Activate / LED_out). It samples the scanned anode and segment lines, resolves each glyph back to a hex nibble, and reassembles the full 32-bit displayed word. Used in simulation benches and as an on-chip self-check, so register values can be compared without watching waveforms.

Parameters:
DIGITS, 8, number of scanned digits; word width is 4*DIGITS.
STABLE_CYCLES, 4, consecutive identical samples of anode+segments required before a digit is accepted (range 1..255).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
Anode_Activate  input  DIGITS  active-low digit enables; bit i low selects digit i
LED_out  input  7  active-low segments, bit6=a, bit5=b, ..., bit0=g
value  output  4*DIGITS  last complete decoded word; digit i maps to value[4i+3:4i]
value_valid  output  1  one-cycle pulse when value is updated
glyph_err  output  1  sticky: an accepted digit in the current frame had a non-hex pattern
scan_err  output  1  one-cycle pulse when stable anode pattern is not one-hot-low and not all-high

Behaviour:
- Reset (async, rst=1): value=0, value_valid=0, glyph_err=0, scan_err=0, seen mask=0, stability counter=0, FSM=IDLE. Reset mid-frame discards partial digits.
- Inputs registered once on entry (1-cycle sample stage); all decisions use registered copies.
- Stability: counter resets to 1 whenever {anode,segments} differs from the previous sample; otherwise increments, saturating at STABLE_CYCLES.
- FSM per sample: IDLE -> SETTLE on any change; SETTLE -> ACCEPT when counter reaches STABLE_CYCLES; ACCEPT -> HOLD (one cycle of action); HOLD -> SETTLE on next change. A pattern is acted on exactly once, however long it stays stable.
- ACCEPT actions:
  - Anode all-high: blanking interval; no action, no error.
  - Anode one-hot-low at index i: decode LED_out; store nibble in digit register i; set seen[i]. A non-hex pattern stores 0 and sets glyph_err.
  - Anything else (zero-hot or multi-hot low): scan_err pulses for one cycle; nothing stored.
- Glyph table, active-low abcdefg: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000. All other codes are invalid.
- Frame complete: the cycle after seen becomes all-ones, value <= digit registers, value_valid pulses, and seen clears. glyph_err clears in the same cycle unless that completion cycle itself accepts a bad glyph; in that case it stays set for the new frame.
- Re-accepting a digit already in seen overwrites its nibble (latest wins) and does not complete the frame early.
- Latency: from the first cycle of a stable pattern to the digit store is STABLE_CYCLES+1 clocks (sample register plus settle). value_valid follows the last digit's store by 1 clock.
- value holds between frames; it never shows a partial frame.

Decomposition:
- Shared package seg7_pkg: glyph constants SEG_0..SEG_F (7-bit active-low), SEG_BLANK=7'b1111111, and FSM state enum (IDLE, SETTLE, ACCEPT, HOLD).
- One sub-module, seg7_glyph_decode: combinational, 7-bit pattern in -> 4-bit nibble + valid flag. Reused by any future display checker.

Test Plan:
- Reset then scan digits 0..7 showing 0x1234ABCD (digit0=D ... digit7=1), each held 10 cycles with 2 blank cycles between -> one value_valid pulse, value=32'h1234ABCD, glyph_err=0, scan_err=0.
- Glitch: hold digit 3 with "7" for 2 cycles, then "E" for 10 cycles (STABLE_CYCLES=4) -> only E accepted; value[15:12]=4'hE after the frame completes.
- Invalid glyph 1111110 on digit 5 during a full scan -> glyph_err=1, value[23:20]=0, value_valid still pulses; glyph_err clears on the next clean frame.
- Anode 8'b11110011 stable 6 cycles -> exactly one scan_err pulse, seen unchanged, no value_valid.
- Scan digits 0..3, assert rst for 1 cycle, then scan 0..7 showing 0xFFFF0000 -> a single value_valid with value=32'hFFFF0000; no earlier pulse.
- Hold digit 2 stable for 100 cycles -> exactly one acceptance; the frame does not complete until the other seven digits are seen.
